// File: rtl/img_stream_tx.sv
// img_stream_tx
//   Video-stream source at the head of the processing chain. Generates
//   H/V sync timing from parameters and fills active pixels either from a
//   first-word-fall-through pixel FIFO or from a built-in test pattern.
//
// Ports
//   clk, rst_n        pixel clock, async active-low reset
//   enable            run request (a stop only takes effect at frame end)
//   pattern_sel       0 FIFO, 1 h-ramp, 2 8x8 checker, 3 flat mid-grey
//   fifo_empty/data   FWFT pixel FIFO head
//   fifo_rd_en        combinational pop, only for active pixels in mode 0
//   post_img_*        registered vsync/hsync/valid/data (latency 1)
//   frame_done        1-clk pulse aligned with the last pixel slot of a frame
//   underflow_cnt     active pixels that found the FIFO empty, this frame
module img_stream_tx #(
   parameter int          DATA_WIDTH = 8,
   parameter logic [10:0] H_SYNC     = 11'd40,
   parameter logic [10:0] H_BACK     = 11'd220,
   parameter logic [10:0] H_DISP     = 11'd1280,
   parameter logic [10:0] H_FRONT    = 11'd110,
   parameter logic [10:0] H_TOTAL    = 11'd1650,
   parameter logic [10:0] V_SYNC     = 11'd5,
   parameter logic [10:0] V_BACK     = 11'd20,
   parameter logic [10:0] V_DISP     = 11'd720,
   parameter logic [10:0] V_FRONT    = 11'd5,
   parameter logic [10:0] V_TOTAL    = 11'd750
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [1:0]            pattern_sel,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  post_img_vsync,
   output logic                  post_img_hsync,
   output logic                  post_img_valid,
   output logic [DATA_WIDTH-1:0] post_img_data,
   output logic                  frame_done,
   output logic [15:0]           underflow_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [10:0] H_ACT_S = H_SYNC + H_BACK;
   localparam logic [10:0] H_ACT_E = H_ACT_S + H_DISP;
   localparam logic [10:0] V_ACT_S = V_SYNC + V_BACK;
   localparam logic [10:0] V_ACT_E = V_ACT_S + V_DISP;

   state_t                state_q, state_d;
   logic [10:0]           h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [1:0]            mode_q, mode_d;
   logic                  vsync_q, vsync_d, hsync_q, hsync_d, valid_q, valid_d;
   logic                  frame_done_q, frame_done_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           uf_q, uf_d;

   logic running, h_last, frame_end, at_origin, active, pop, starve;

   always_comb begin
      running   = (state_q != IDLE);
      h_last    = (h_cnt_q == H_TOTAL - 11'd1);
      frame_end = running && h_last && (v_cnt_q == V_TOTAL - 11'd1);
      at_origin = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
      active    = running && (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E)
                          && (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
      pop       = active && (mode_q == 2'd0) && !fifo_empty;
      starve    = active && (mode_q == 2'd0) && fifo_empty;
   end

   assign fifo_rd_en = pop;

   // A stop request is parked in DRAIN so the current frame always finishes;
   // re-enabling during DRAIN resumes without losing a frame slot.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (frame_end) state_d = enable ? RUN : IDLE;
                  else if (!enable) state_d = DRAIN;
         DRAIN:   if (enable) state_d = RUN;
                  else if (frame_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters rest at (0,0) in IDLE, so a new frame starts cleanly.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (running) begin
         h_cnt_d = h_last ? 11'd0 : h_cnt_q + 11'd1;
         if (h_last) v_cnt_d = (v_cnt_q == V_TOTAL - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
      end
      mode_d = at_origin ? pattern_sel : mode_q;
   end

   always_comb begin
      vsync_d      = running && (v_cnt_q < V_SYNC);
      hsync_d      = running && (h_cnt_q < H_SYNC);
      valid_d      = active;
      frame_done_d = frame_end;
      data_d       = '0;
      if (active) begin
         unique case (mode_q)
            2'd0: data_d = pop ? fifo_data : '0;
            2'd1: data_d = DATA_WIDTH'(h_cnt_q - H_ACT_S);
            2'd2: data_d = ((((h_cnt_q - H_ACT_S) ^ (v_cnt_q - V_ACT_S)) & 11'd8) != 11'd0)
                           ? '1 : '0;
            default: data_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         endcase
      end
      // Previous frame's total stays visible through the frame_done slot.
      uf_d = uf_q;
      if (running && at_origin)            uf_d = '0;
      else if (starve && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         mode_q       <= '0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         data_q       <= '0;
         uf_q         <= '0;
      end else begin
         state_q      <= state_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         mode_q       <= mode_d;
         vsync_q      <= vsync_d;
         hsync_q      <= hsync_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         data_q       <= data_d;
         uf_q         <= uf_d;
      end
   end

   assign post_img_vsync = vsync_q;
   assign post_img_hsync = hsync_q;
   assign post_img_valid = valid_q;
   assign post_img_data  = data_q;
   assign frame_done     = frame_done_q;
   assign underflow_cnt  = uf_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed bench for img_stream_tx: small timing (15x8 frame) for the main
// instance, a second 23x20 instance with a 16x16 active window for the
// checker pattern.
module tb_img_stream_tx;
   localparam int FR = 120;   // clocks per frame, main instance
   localparam int FR2 = 460;  // clocks per frame, checker instance

   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, enable2 = 1'b0;
   logic [1:0] pattern_sel = 2'd1;
   logic [1:0] pattern_sel2 = 2'd2;
   logic fifo_empty, fifo_rd_en;
   logic [7:0] fifo_data;
   logic vs, hs, vld, fd;
   logic [7:0] dat;
   logic [15:0] ufc;
   logic fifo_empty2 = 1'b1;
   logic [7:0] fifo_data2 = 8'h00;
   logic rd2, vs2, hs2, vld2, fd2;
   logic [7:0] dat2;
   logic [15:0] ufc2;

   img_stream_tx #(.DATA_WIDTH(8),
      .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd15),
      .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1), .V_TOTAL(11'd8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
      .post_img_vsync(vs), .post_img_hsync(hs), .post_img_valid(vld),
      .post_img_data(dat), .frame_done(fd), .underflow_cnt(ufc));

   img_stream_tx #(.DATA_WIDTH(8),
      .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd16), .H_FRONT(11'd2), .H_TOTAL(11'd23),
      .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd16), .V_FRONT(11'd1), .V_TOTAL(11'd20)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .pattern_sel(pattern_sel2),
      .fifo_empty(fifo_empty2), .fifo_data(fifo_data2), .fifo_rd_en(rd2),
      .post_img_vsync(vs2), .post_img_hsync(hs2), .post_img_valid(vld2),
      .post_img_data(dat2), .frame_done(fd2), .underflow_cnt(ufc2));

   always #5 clk = ~clk;

   // FWFT FIFO model
   logic [7:0] fmem [0:63];
   int rd_ptr = 0, wr_ptr = 0, pop_cnt = 0, bad_pop = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_data  = fmem[rd_ptr % 64];
   always @(posedge clk) if (fifo_rd_en) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   logic s_vld [0:FR-1];
   logic s_hs  [0:FR-1];
   logic s_vs  [0:FR-1];
   logic s_fd  [0:FR-1];
   logic [7:0]  s_dat [0:FR-1];
   logic [15:0] s_uf  [0:FR-1];
   logic [7:0] vq [$];
   int n_vld, n_hs, n_vs, n_fd, first_vld, nz_out, n_lines;

   task automatic load_fifo(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) fmem[(wr_ptr + i) % 64] = base + 8'(i);
      wr_ptr = wr_ptr + n;
   endtask

   // Waits for the first output slot of a frame (vsync & hsync both high).
   task automatic sync(output int w);
      w = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (vs && hs) begin w = k; break; end
      end
      chk("sync_found", (w >= 0), 1);
   endtask

   // Captures one frame starting at the current (sync) negedge.
   task automatic collect(input int drop_at, input int rise_at, input logic [1:0] psel_drop);
      for (int i = 0; i < FR; i++) begin
         if (i > 0) @(negedge clk);
         s_vld[i] = vld; s_hs[i] = hs; s_vs[i] = vs; s_fd[i] = fd;
         s_dat[i] = dat; s_uf[i] = ufc;
         if (i == drop_at) begin enable = 1'b0; pattern_sel = psel_drop; end
         if (i == rise_at) enable = 1'b1;
      end
   endtask

   task automatic analyze();
      n_vld = 0; n_hs = 0; n_vs = 0; n_fd = 0; first_vld = -1; nz_out = 0; n_lines = 0;
      vq.delete();
      for (int i = 0; i < FR; i++) begin
         if (s_vld[i]) begin
            n_vld++; vq.push_back(s_dat[i]);
            if (first_vld < 0) first_vld = i;
         end else if (s_dat[i] != 8'h00) nz_out++;
         if (s_hs[i]) n_hs++;
         if (s_vs[i]) n_vs++;
         if (s_fd[i]) n_fd++;
      end
      for (int l = 0; l < 8; l++) begin
         int any = 0;
         for (int h = 0; h < 15; h++) if (s_vld[l*15+h]) any = 1;
         n_lines += any;
      end
   endtask

   task automatic chk_ramp_frame(input string p);
      int errs = 0;
      analyze();
      chk({p, "_nvld"}, n_vld, 32);
      chk({p, "_nhs"}, n_hs, 16);
      chk({p, "_nvs"}, n_vs, 15);
      chk({p, "_vld_lines"}, n_lines, 4);
      chk({p, "_first_vld"}, first_vld, 50);
      chk({p, "_hs_rise"}, {s_hs[44], s_hs[45], s_hs[46], s_hs[47]}, 4'b0110);
      chk({p, "_fd_last"}, s_fd[FR-1], 1);
      chk({p, "_nfd"}, n_fd, 1);
      chk({p, "_data_outside"}, nz_out, 0);
      for (int k = 0; k < vq.size(); k++) if (vq[k] != 8'(k % 8)) errs++;
      chk({p, "_ramp_errs"}, errs, 0);
   endtask

   initial begin
      int w, p0, errs, nz, q2n, rd2n;
      logic [7:0] q2 [$];
      for (int i = 0; i < 64; i++) fmem[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", {vs, hs, vld, fd, fifo_rd_en}, 5'b0);
      chk("rst_data", dat, 8'h00);
      chk("rst_uf", ufc, 16'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_outs", {vs, hs, vld, fd, dat}, 12'h0);

      // mode 1 ramp
      pattern_sel = 2'd1; enable = 1'b1; p0 = pop_cnt;
      sync(w);
      chk("start_lat", w, 1);
      collect(118, -1, 2'd1);
      chk_ramp_frame("ramp");
      chk("ramp_no_pop", pop_cnt - p0, 0);

      // mode 0, FIFO holds exactly one frame
      load_fifo(32, 8'h10); pattern_sel = 2'd0; enable = 1'b1; p0 = pop_cnt;
      sync(w);
      collect(118, -1, 2'd0);
      analyze(); errs = 0;
      for (int k = 0; k < vq.size(); k++) if (vq[k] != 8'h10 + 8'(k)) errs++;
      chk("fifo32_nvld", n_vld, 32);
      chk("fifo32_data_errs", errs, 0);
      chk("fifo32_pops", pop_cnt - p0, 32);
      chk("fifo32_uf", s_uf[FR-1], 0);
      chk("fifo32_data_outside", nz_out, 0);

      // mode 0, FIFO runs dry after 20 pixels
      load_fifo(20, 8'h40); enable = 1'b1; p0 = pop_cnt;
      sync(w);
      collect(118, -1, 2'd0);
      analyze(); errs = 0;
      for (int k = 0; k < vq.size(); k++)
         if (vq[k] != ((k < 20) ? 8'h40 + 8'(k) : 8'h00)) errs++;
      chk("fifo20_nvld", n_vld, 32);
      chk("fifo20_data_errs", errs, 0);
      chk("fifo20_pops", pop_cnt - p0, 20);
      chk("fifo20_uf", s_uf[FR-1], 12);
      chk("fifo_empty_pops", bad_pop, 0);
      @(negedge clk);
      chk("uf_hold_idle", ufc, 12);

      // mode 3, drop enable mid-frame and re-raise it: no gap
      pattern_sel = 2'd3; enable = 1'b1;
      sync(w);
      collect(20, 40, 2'd3);
      analyze(); errs = 0;
      for (int k = 0; k < vq.size(); k++) if (vq[k] != 8'h80) errs++;
      chk("flat_nvld", n_vld, 32);
      chk("flat_errs", errs, 0);
      chk("uf_cleared", s_uf[0], 0);
      sync(w);
      chk("drain_rerun_nogap", w, 0);
      // drop enable and change pattern mid-frame: frame completes unchanged
      collect(30, -1, 2'd1);
      analyze(); errs = 0;
      for (int k = 0; k < vq.size(); k++) if (vq[k] != 8'h80) errs++;
      chk("drain_nvld", n_vld, 32);
      chk("drain_psel_ignored", errs, 0);
      chk("drain_nfd", n_fd, 1);
      chk("drain_fd_last", s_fd[FR-1], 1);
      nz = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (vs || hs || vld || fd || fifo_rd_en || dat != 8'h00) nz++;
      end
      chk("idle_after_drain", nz, 0);

      // async reset during an active pixel
      enable = 1'b1;
      sync(w);
      repeat (55) @(negedge clk);
      chk("pre_rst_vld", vld, 1);
      chk("pre_rst_data", dat, 8'h05);
      #1 rst_n = 1'b0;
      #1 chk("async_rst_outs", {vs, hs, vld, fd, fifo_rd_en}, 5'b0);
      chk("async_rst_data", dat, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      sync(w);
      chk("rst_restart_lat", w, 1);
      collect(118, -1, 2'd1);
      chk_ramp_frame("post_rst");

      // checker pattern on the 16x16 instance
      enable2 = 1'b1; w = -1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (vs2 && hs2) begin w = k; break; end
      end
      chk("ckr_sync_found", (w >= 0), 1);
      rd2n = 0;
      for (int i = 0; i < FR2; i++) begin
         if (i > 0) @(negedge clk);
         if (vld2) q2.push_back(dat2);
         if (rd2) rd2n++;
      end
      enable2 = 1'b0;
      q2n = q2.size();
      chk("ckr_nvld", q2n, 256);
      errs = 0;
      for (int k = 0; k < q2n; k++)
         if (q2[k] != (((((k % 16) / 8) ^ ((k / 16) / 8)) != 0) ? 8'hFF : 8'h00)) errs++;
      chk("ckr_errs", errs, 0);
      if (q2n == 256) begin
         chk("ckr_r0x0", q2[0], 8'h00);
         chk("ckr_r0x8", q2[8], 8'hFF);
         chk("ckr_r8x0", q2[128], 8'hFF);
         chk("ckr_r8x8", q2[136], 8'h00);
      end
      chk("ckr_no_pop", rd2n, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
